// File: rtl/atm_session_ctrl.sv
// ATM session controller: account/PIN store, card-PIN-menu-exec FSM, one-cycle done pulse with status.
// Latency: strobe to done 1 cycle, op to done 2 cycles; no backpressure, strobes outside PIN_WAIT/MENU are dropped.
module atm_session_ctrl #(
  parameter int NUM_ACCOUNTS = 10,
  parameter int BAL_W = 32,
  parameter int PIN_W = 16,
  parameter int MAX_PIN_TRIES = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SESSION_LIMIT = 5000,
  parameter int INIT_BALANCE = 1000,
  parameter logic [PIN_W-1:0] INIT_PIN = 16'h1234,
  localparam int ACC_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    card_valid,
  input  logic [ACC_W-1:0]        acc_num,
  input  logic                    pin_valid,
  input  logic [PIN_W-1:0]        pin,
  input  logic                    op_valid,
  input  logic [2:0]              op,
  input  logic [BAL_W-1:0]        amount,
  input  logic [PIN_W-1:0]        new_pin,
  output logic                    done,
  output logic [2:0]              status,
  output logic [BAL_W-1:0]        balance,
  output logic [2:0]              state,
  output logic [NUM_ACCOUNTS-1:0] locked
);

  localparam logic [2:0] S_IDLE = 3'd0, S_PIN_WAIT = 3'd1, S_MENU = 3'd2, S_EXEC = 3'd3, S_EJECT = 3'd4;
  localparam logic [2:0] OP_BALANCE = 3'd0, OP_WITHDRAW = 3'd1, OP_DEPOSIT = 3'd2, OP_CHANGE_PIN = 3'd3,
                         OP_EXIT = 3'd4;
  localparam logic [2:0] ST_OK = 3'd0, ST_BAD_ACC = 3'd1, ST_BAD_PIN = 3'd2, ST_LOCKED = 3'd3,
                         ST_NSF = 3'd4, ST_OVER_LIMIT = 3'd5, ST_OVERFLOW = 3'd6, ST_TIMEOUT = 3'd7;

  localparam int TRY_W = $clog2(MAX_PIN_TRIES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TRY_W-1:0] TRY_MAX   = TRY_W'(MAX_PIN_TRIES);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BAL_W-1:0] INIT_BAL  = BAL_W'(INIT_BALANCE);
  localparam logic [BAL_W:0]   LIMIT_V   = (BAL_W + 1)'(SESSION_LIMIT);
  localparam logic [ACC_W:0]   NUM_ACC_V = (ACC_W + 1)'(NUM_ACCOUNTS);

  logic [BAL_W-1:0] bal_mem [NUM_ACCOUNTS];
  logic [PIN_W-1:0] pin_mem [NUM_ACCOUNTS];
  logic [TRY_W-1:0] tries   [NUM_ACCOUNTS];

  logic [ACC_W-1:0] cur_acc;
  logic [BAL_W-1:0] sess_total;
  logic [BAL_W-1:0] amt_q;
  logic [PIN_W-1:0] npin_q;
  logic [2:0]       op_q;
  logic [TMO_W-1:0] tmo_cnt;

  logic [BAL_W-1:0] cur_bal;
  logic [BAL_W:0]   wd_total;
  logic [BAL_W:0]   dep_sum;
  logic [TRY_W-1:0] tries_nxt;
  logic             acc_ok;
  logic             op_ok;
  logic             tmo_hit;

  assign cur_bal   = bal_mem[cur_acc];
  assign wd_total  = {1'b0, sess_total} + {1'b0, amt_q};
  assign dep_sum   = {1'b0, cur_bal} + {1'b0, amt_q};
  assign tries_nxt = tries[cur_acc] + TRY_W'(1);
  assign acc_ok    = {1'b0, acc_num} < NUM_ACC_V;
  assign op_ok     = op_valid && (op <= OP_EXIT);
  assign tmo_hit   = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        bal_mem[i] <= INIT_BAL;
        pin_mem[i] <= INIT_PIN;
        tries[i]   <= '0;
      end
      locked     <= '0;
      done       <= 1'b0;
      status     <= ST_OK;
      balance    <= '0;
      state      <= S_IDLE;
      cur_acc    <= '0;
      sess_total <= '0;
      amt_q      <= '0;
      npin_q     <= '0;
      op_q       <= OP_BALANCE;
      tmo_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (card_valid) begin
            if (!acc_ok) begin
              done   <= 1'b1;
              status <= ST_BAD_ACC;
              state  <= S_EJECT;
            end else if (locked[acc_num]) begin
              done   <= 1'b1;
              status <= ST_LOCKED;
              state  <= S_EJECT;
            end else begin
              cur_acc    <= acc_num;
              sess_total <= '0;
              tmo_cnt    <= '0;
              state      <= S_PIN_WAIT;
            end
          end
        end
        S_PIN_WAIT: begin
          if (!card_valid) begin
            state <= S_IDLE;
          end else if (pin_valid) begin
            tmo_cnt <= '0;
            done    <= 1'b1;
            if (pin == pin_mem[cur_acc]) begin
              tries[cur_acc] <= '0;
              balance        <= cur_bal;
              status         <= ST_OK;
              state          <= S_MENU;
            end else begin
              tries[cur_acc] <= tries_nxt;
              if (tries_nxt == TRY_MAX) begin
                locked[cur_acc] <= 1'b1;
                status          <= ST_LOCKED;
                state           <= S_EJECT;
              end else begin
                status <= ST_BAD_PIN;
              end
            end
          end else if (tmo_hit) begin
            done   <= 1'b1;
            status <= ST_TIMEOUT;
            state  <= S_EJECT;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_MENU: begin
          if (!card_valid) begin
            state <= S_IDLE;
          end else if (op_ok) begin
            op_q    <= op;
            amt_q   <= amount;
            npin_q  <= new_pin;
            tmo_cnt <= '0;
            state   <= S_EXEC;
          end else if (tmo_hit) begin
            done   <= 1'b1;
            status <= ST_TIMEOUT;
            state  <= S_EJECT;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_EXEC: begin
          // Failed ops fall through with stored state untouched; balance output re-reads the store.
          done    <= 1'b1;
          status  <= ST_OK;
          balance <= cur_bal;
          tmo_cnt <= '0;
          state   <= (op_q == OP_EXIT) ? S_EJECT : S_MENU;
          case (op_q)
            OP_WITHDRAW: begin
              if (wd_total > LIMIT_V) begin
                status <= ST_OVER_LIMIT;
              end else if (amt_q > cur_bal) begin
                status <= ST_NSF;
              end else begin
                bal_mem[cur_acc] <= cur_bal - amt_q;
                balance          <= cur_bal - amt_q;
                sess_total       <= sess_total + amt_q;
              end
            end
            OP_DEPOSIT: begin
              if (dep_sum[BAL_W]) begin
                status <= ST_OVERFLOW;
              end else begin
                bal_mem[cur_acc] <= dep_sum[BAL_W-1:0];
                balance          <= dep_sum[BAL_W-1:0];
              end
            end
            OP_CHANGE_PIN: begin
              if (npin_q == '0) status <= ST_BAD_PIN;
              else pin_mem[cur_acc] <= npin_q;
            end
            default: ;
          endcase
        end
        S_EJECT: begin
          if (!card_valid) begin
            state   <= S_IDLE;
            balance <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: directed session scenarios then randomized traffic, all checked each cycle
// against a transaction-level model of accounts, sessions and timeouts.
module tb_atm_session_ctrl;

  localparam int N    = 10;
  localparam int T    = 40;
  localparam int MAXT = 3;
  localparam longint unsigned LIM = 5000;

  logic        clk;
  logic        rst;
  logic        card_valid;
  logic [3:0]  acc_num;
  logic        pin_valid;
  logic [15:0] pin;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] amount;
  logic [15:0] new_pin;
  logic        done;
  logic [2:0]  status;
  logic [31:0] balance;
  logic [2:0]  state;
  logic [9:0]  locked;

  atm_session_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .card_valid(card_valid), .acc_num(acc_num),
    .pin_valid(pin_valid), .pin(pin), .op_valid(op_valid), .op(op),
    .amount(amount), .new_pin(new_pin), .done(done), .status(status),
    .balance(balance), .state(state), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: account store plus session context.
  longint unsigned m_bal[N];
  int unsigned     m_pin[N];
  int              m_tries[N];
  bit              m_lock[N];
  int              ms;
  int              m_acc;
  int              m_idle;
  longint unsigned m_sess;
  int              m_op;
  longint unsigned m_amt;
  int unsigned     m_npin;
  bit              e_done;
  int              e_status;
  longint unsigned e_bal;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_bal[i] = 1000; m_pin[i] = 16'h1234; m_tries[i] = 0; m_lock[i] = 0;
    end
    ms = 0; m_acc = 0; m_idle = 0; m_sess = 0; m_op = 0; m_amt = 0; m_npin = 0;
    e_done = 0; e_status = 0; e_bal = 0;
  endfunction

  function automatic void finish_with(input int st, input int nxt);
    e_done = 1; e_status = st; ms = nxt;
  endfunction

  function automatic void m_step();
    int st;
    e_done = 0;
    if (rst) begin
      m_reset();
      return;
    end
    case (ms)
      0: if (card_valid) begin
        if (int'(acc_num) >= N) finish_with(1, 4);
        else if (m_lock[acc_num]) finish_with(3, 4);
        else begin m_acc = int'(acc_num); m_sess = 0; m_idle = 0; ms = 1; end
      end
      1: begin
        if (!card_valid) ms = 0;
        else if (pin_valid) begin
          m_idle = 0;
          if (int'(pin) == int'(m_pin[m_acc])) begin
            m_tries[m_acc] = 0; e_bal = m_bal[m_acc]; finish_with(0, 2);
          end else begin
            m_tries[m_acc]++;
            if (m_tries[m_acc] >= MAXT) begin m_lock[m_acc] = 1; finish_with(3, 4); end
            else finish_with(2, 1);
          end
        end else begin
          m_idle++;
          if (m_idle >= T) finish_with(7, 4);
        end
      end
      2: begin
        if (!card_valid) ms = 0;
        else if (op_valid && op <= 3'd4) begin
          m_op = int'(op); m_amt = amount; m_npin = new_pin; m_idle = 0; ms = 3;
        end else begin
          m_idle++;
          if (m_idle >= T) finish_with(7, 4);
        end
      end
      3: begin
        st = 0;
        case (m_op)
          1: if (m_sess + m_amt > LIM) st = 5;
             else if (m_amt > m_bal[m_acc]) st = 4;
             else begin m_bal[m_acc] -= m_amt; m_sess += m_amt; end
          2: if (m_bal[m_acc] + m_amt > 64'hFFFF_FFFF) st = 6;
             else m_bal[m_acc] += m_amt;
          3: if (m_npin == 0) st = 2;
             else m_pin[m_acc] = m_npin;
          default: ;
        endcase
        e_bal = m_bal[m_acc];
        m_idle = 0;
        finish_with(st, (m_op == 4) ? 4 : 2);
      end
      4: if (!card_valid) begin ms = 0; e_bal = 0; end
      default: ms = 0;
    endcase
  endfunction

  // One clock: advance the model on the applied inputs, then compare every output after the edge.
  task automatic tick();
    logic [9:0] exp_lock;
    m_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) exp_lock[i] = m_lock[i];
    chk("done", done, e_done);
    chk("status", status, e_status);
    chk("balance", balance, e_bal);
    chk("state", state, ms);
    chk("locked", locked, exp_lock);
    pin_valid = 0;
    op_valid  = 0;
  endtask

  task automatic insert(input int a);
    card_valid = 1; acc_num = 4'(a); tick();
  endtask
  task automatic remove();
    card_valid = 0; tick();
  endtask
  task automatic enter_pin(input int p);
    pin_valid = 1; pin = 16'(p); tick();
  endtask
  task automatic do_op(input int o, input longint unsigned a, input int np);
    op_valid = 1; op = 3'(o); amount = 32'(a); new_pin = 16'(np); tick(); tick();
  endtask
  task automatic expect_done(input string nm, input int st);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_status"}, status, st);
  endtask

  int act;

  initial begin
    m_reset();
    rst = 1; card_valid = 0; acc_num = 0; pin_valid = 0; pin = 0;
    op_valid = 0; op = 0; amount = 0; new_pin = 0;
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_balance", balance, 0);
    chk("rst_locked", locked, 0);
    rst = 0;

    // Acc 3: withdraw then balance
    insert(3);
    chk("acc3_state", state, 1);
    enter_pin(16'h1234);  expect_done("acc3_pin", 0); chk("acc3_bal0", balance, 1000);
    do_op(1, 300, 0);     expect_done("acc3_wd", 0);  chk("acc3_bal1", balance, 700);
    do_op(0, 0, 0);       expect_done("acc3_bal", 0); chk("acc3_bal2", balance, 700);
    do_op(4, 0, 0);       expect_done("acc3_exit", 0); chk("acc3_eject", state, 4);
    remove();             chk("acc3_idle_bal", balance, 0);

    // Acc 5: lockout after three wrong PINs
    insert(5);
    enter_pin(16'h1111); expect_done("acc5_try1", 2);
    enter_pin(16'h2222); expect_done("acc5_try2", 2);
    enter_pin(16'h3333); expect_done("acc5_try3", 3);
    chk("acc5_lockbit", locked[5], 1); chk("acc5_eject", state, 4);
    remove();
    insert(5); expect_done("acc5_relock", 3);
    remove();

    // Acc 0: NSF, limit, overflow, PIN change
    insert(0); enter_pin(16'h1234);
    do_op(1, 1001, 0);  expect_done("acc0_nsf", 4); chk("acc0_nsf_bal", balance, 1000);
    do_op(2, 9000, 0);  expect_done("acc0_dep", 0); chk("acc0_dep_bal", balance, 10000);
    do_op(1, 5000, 0);  expect_done("acc0_wd5k", 0); chk("acc0_wd_bal", balance, 5000);
    do_op(1, 1, 0);     expect_done("acc0_limit", 5); chk("acc0_lim_bal", balance, 5000);
    do_op(2, 64'hFFFF_FF00 - 5000, 0); chk("acc0_big_bal", balance, 32'hFFFF_FF00);
    do_op(2, 32'h100, 0); expect_done("acc0_ovf", 6); chk("acc0_ovf_bal", balance, 32'hFFFF_FF00);
    do_op(3, 0, 0);      expect_done("acc0_pin0", 2);
    do_op(3, 0, 16'hBEEF); expect_done("acc0_newpin", 0);
    do_op(4, 0, 0);      expect_done("acc0_exit", 0);
    remove();
    insert(0); enter_pin(16'hBEEF); expect_done("acc0_beef", 0);
    do_op(4, 0, 0); remove();

    // Bad account, then menu timeout
    insert(12); expect_done("acc12", 1); chk("acc12_eject", state, 4);
    remove();
    insert(1); enter_pin(16'h1234);
    repeat (T - 1) tick();
    chk("tmo_not_yet", done, 0);
    tick(); expect_done("tmo", 7); chk("tmo_eject", state, 4);
    tick(); chk("tmo_hold", state, 4);
    remove(); chk("tmo_idle", state, 0);

    // Reset in the middle of an EXEC
    insert(2); enter_pin(16'h1234);
    op_valid = 1; op = 3'd2; amount = 50; tick();
    chk("rx_exec", state, 3);
    rst = 1; card_valid = 0; tick();
    chk("rx_done", done, 0); chk("rx_state", state, 0);
    rst = 0;
    insert(2); enter_pin(16'h1234); chk("rx_bal2", balance, 1000);
    remove();
    insert(0); enter_pin(16'h1234); expect_done("rx_acc0", 0); chk("rx_bal0", balance, 1000);
    remove();

    // Randomized traffic
    act = 3;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc % 150 == 0) act = ($urandom_range(0, 3) == 0) ? 80 : $urandom_range(1, 5);
      rst = ($urandom_range(0, 699) == 0);
      case (ms)
        0: card_valid = ($urandom_range(0, 3) == 0);
        4: card_valid = ($urandom_range(0, 2) != 0);
        default: card_valid = ($urandom_range(0, 59) != 0);
      endcase
      acc_num = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      pin_valid = ($urandom_range(0, act - 1) == 0);
      pin = (ms == 1 && $urandom_range(0, 3) != 0) ? 16'(m_pin[m_acc]) : 16'($urandom);
      op_valid = ($urandom_range(0, act - 1) == 0);
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: amount = 32'($urandom_range(0, 1500));
        1: amount = 32'($urandom_range(4000, 6000));
        2: amount = $urandom;
        default: amount = 32'hFFFF_FFFF - 32'($urandom_range(0, 20000));
      endcase
      new_pin = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Parametrised, fully synchronous ATM session controller: owns the per-account balance and PIN store, runs card/PIN/menu/execute sessions through a registered FSM, and reports every outcome as a one-cycle `done` pulse with a status code. Adds PIN-retry lockout, a per-session withdrawal limit, deposit overflow protection, and an inactivity timeout. Sits between the front-panel/keypad front end and the display/dispenser logic.

## Interface
- `NUM_ACCOUNTS`, 10: number of accounts; `ACC_W = $clog2(NUM_ACCOUNTS)` (min 1).
- `BAL_W`, 32: balance and amount width (unsigned).
- `PIN_W`, 16: PIN width.
- `MAX_PIN_TRIES`, 3: consecutive wrong PINs before the account locks (≥1).
- `TIMEOUT_CYCLES`, 1000: idle cycles allowed in PIN_WAIT/MENU (≥2).
- `SESSION_LIMIT`, 5000: maximum total withdrawn per session.
- `INIT_BALANCE`, 1000: every account's balance after reset.
- `INIT_PIN`, 16'h1234: every account's PIN after reset.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `card_valid` in 1: card present; level.
- `acc_num` in ACC_W: account number, sampled in IDLE.
- `pin_valid` in 1: one-cycle strobe qualifying `pin`.
- `pin` in PIN_W: entered PIN.
- `op_valid` in 1: one-cycle strobe qualifying `op`/`amount`/`new_pin`.
- `op` in 3: 0 BALANCE, 1 WITHDRAW, 2 DEPOSIT, 3 CHANGE_PIN, 4 EXIT; 5–7 are ignored.
- `amount` in BAL_W: withdraw/deposit amount.
- `new_pin` in PIN_W: replacement PIN.
- `done` out 1: one-cycle pulse; `status` is valid while it is high.
- `status` out 3: 0 OK, 1 BAD_ACC, 2 BAD_PIN, 3 LOCKED, 4 NSF, 5 OVER_LIMIT, 6 OVERFLOW, 7 TIMEOUT.
- `balance` out BAL_W: balance of the session account.
- `state` out 3: FSM state code.
- `locked` out NUM_ACCOUNTS: per-account lock bitmap.

## Operation
- States: IDLE=0, PIN_WAIT=1, MENU=2, EXEC=3, EJECT=4.
- Reset: balances = INIT_BALANCE, PINs = INIT_PIN, try counters = 0, `locked` = 0. Outputs: `done`=0, `status`=0, `balance`=0, `state`=IDLE.
- **IDLE**, `card_valid`=1:
  - `acc_num` ≥ NUM_ACCOUNTS → `done` with BAD_ACC, go to EJECT.
  - Account locked → `done` with LOCKED, go to EJECT.
  - Otherwise latch the account index, clear the session withdrawn total, go to PIN_WAIT.
- **PIN_WAIT**, `pin_valid`:
  - PIN matches → try counter = 0, `balance` = stored balance, `done` with OK, go to MENU.
  - PIN mismatches → try counter +1. If it reaches MAX_PIN_TRIES: set the lock bit, `done` with LOCKED, go to EJECT. Otherwise `done` with BAD_PIN, stay in PIN_WAIT.
- **MENU**, `op_valid` with `op` ≤ 4 → latch op/amount/new_pin, go to EXEC. Undefined ops are dropped and do not reset the timeout.
- **EXEC** (exactly one cycle, always completes, `card_valid` ignored):
  - BALANCE → OK.
  - WITHDRAW: if session_total + amount > SESSION_LIMIT → OVER_LIMIT. Else if amount > balance → NSF. Else balance −= amount, session_total += amount, OK. The limit check is computed at BAL_W+1 bits.
  - DEPOSIT: if balance + amount exceeds 2^BAL_W−1 → OVERFLOW. Else balance += amount, OK.
  - CHANGE_PIN: if new_pin = 0 → BAD_PIN. Else store new_pin, OK.
  - EXIT → OK, go to EJECT. All other ops return to MENU.
  - Failed ops leave all stored state unchanged.
- **Timeout:** counter runs in PIN_WAIT/MENU and clears on state entry and on each accepted `pin_valid`/`op_valid`. When it reaches TIMEOUT_CYCLES−1 → `done` with TIMEOUT, go to EJECT.
- **Card removal:** `card_valid`=0 in PIN_WAIT/MENU → go to IDLE, no `done`.
- **EJECT:** wait for `card_valid`=0, then go to IDLE and set `balance` to 0.
- **Priority in the same cycle:** `rst` > card removal > accepted strobe > timeout.
- Wrong-PIN counts persist across sessions until a correct PIN or reset; only reset clears a lock.

## Timing
- All outputs are registered.
- A strobe or `card_valid` sampled at edge N → its IDLE/PIN_WAIT `done` is high after edge N+1.
- `op_valid` at edge N → EXEC after edge N+1 → `done`, `status`, `balance` updated after edge N+2. Accept-to-`done` latency is 2 cycles.
- `done` is high for exactly one cycle. `status` holds its value until the next `done`.
- `locked` updates in the same cycle as the LOCKED `done`.
- Strobes in EXEC/EJECT are ignored. The next op can be accepted in the cycle after `done`.
- `rst` mid-EXEC aborts the operation: no `done`, and the store is reinitialised.

## Test plan
- Card acc 3, PIN 0x1234, WITHDRAW 300 → `done` OK after PIN; `done` OK and `balance`=700 two cycles after `op_valid`; BALANCE → 700.
- Acc 5, wrong PIN ×3 → BAD_PIN, BAD_PIN, LOCKED with `locked[5]`=1 → state EJECT. Reinsert acc 5 with correct PIN → LOCKED immediately.
- Acc 0: WITHDRAW 1001 → NSF, balance 1000. DEPOSIT 9000 then WITHDRAW 5000 → OK; WITHDRAW 1 → OVER_LIMIT, balance 5000.
- Balance 0xFFFFFF00, DEPOSIT 0x100 → OVERFLOW, balance unchanged. CHANGE_PIN 0 → BAD_PIN; CHANGE_PIN 0xBEEF → OK; EXIT → OK; reinsert with 0xBEEF → OK.
- Acc 12 → BAD_ACC. In MENU, no input for TIMEOUT_CYCLES → TIMEOUT, then EJECT, then IDLE when the card is removed.
- Assert `rst` during EXEC of DEPOSIT 50 → no `done`; all balances = 1000 and `state`=IDLE.
